// File: rtl/reg_seq_pkg.sv
// Shared types and constants for the register-file instruction sequencer:
// opcodes, FSM state encoding and instruction field positions.
package reg_seq_pkg;

   localparam int DW = 16;
   localparam int AW = 4;

   localparam logic [2:0] OP_LOAD    = 3'b000;
   localparam logic [2:0] OP_ADD     = 3'b001;
   localparam logic [2:0] OP_ADDI    = 3'b010;
   localparam logic [2:0] OP_SUB     = 3'b011;
   localparam logic [2:0] OP_SUBI    = 3'b100;
   localparam logic [2:0] OP_MUL     = 3'b101;
   localparam logic [2:0] OP_CLEAR   = 3'b110;
   localparam logic [2:0] OP_DISPLAY = 3'b111;

   localparam int OPC_MSB  = 15;
   localparam int OPC_LSB  = 13;
   localparam int RD_MSB   = 12;
   localparam int RD_LSB   = 9;
   localparam int RS1_MSB  = 8;
   localparam int RS1_LSB  = 5;
   localparam int RS2_MSB  = 4;
   localparam int RS2_LSB  = 1;
   localparam int IMM5_MSB = 4;
   localparam int IMM9_MSB = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_WAIT,
      S_EXEC,
      S_WB
   } seq_state_t;

   function automatic logic [2:0] f_opcode(input logic [DW-1:0] instr);
      return instr[OPC_MSB:OPC_LSB];
   endfunction

   function automatic logic [AW-1:0] f_rd(input logic [DW-1:0] instr);
      return instr[RD_MSB:RD_LSB];
   endfunction

   function automatic logic [AW-1:0] f_rs1(input logic [DW-1:0] instr);
      return instr[RS1_MSB:RS1_LSB];
   endfunction

   function automatic logic [AW-1:0] f_rs2(input logic [DW-1:0] instr);
      return instr[RS2_MSB:RS2_LSB];
   endfunction

   function automatic logic [4:0] f_imm5(input logic [DW-1:0] instr);
      return instr[IMM5_MSB:0];
   endfunction

   function automatic logic [8:0] f_imm9(input logic [DW-1:0] instr);
      return instr[IMM9_MSB:0];
   endfunction

endpackage

// File: rtl/reg_seq_ctrl_if.sv
// Instruction handshake, register-file port bundle and display/status outputs
// of the sequencer; master is the sequencer, slave the surrounding system.
interface reg_seq_ctrl_if;
   import reg_seq_pkg::*;

   logic [DW-1:0] instr;
   logic          instr_valid;
   logic          instr_ready;
   logic          mem_we;
   logic [2:0]    mem_opcode;
   logic [AW-1:0] mem_destino;
   logic [AW-1:0] mem_addr1;
   logic [AW-1:0] mem_addr2;
   logic [DW-1:0] mem_data_in;
   logic [DW-1:0] mem_rdata1;
   logic [DW-1:0] mem_rdata2;
   logic [DW-1:0] disp_data;
   logic          disp_valid;
   logic          err;
   logic          busy;

   modport master (
      input  instr, instr_valid, mem_rdata1, mem_rdata2,
      output instr_ready, mem_we, mem_opcode, mem_destino, mem_addr1,
             mem_addr2, mem_data_in, disp_data, disp_valid, err, busy
   );

   modport slave (
      output instr, instr_valid, mem_rdata1, mem_rdata2,
      input  instr_ready, mem_we, mem_opcode, mem_destino, mem_addr1,
             mem_addr2, mem_data_in, disp_data, disp_valid, err, busy
   );

endinterface

// File: rtl/reg_seq_ctrl_alu.sv
// Combinational ALU of the sequencer. The multiplier exists only when
// REG_SEQ_MUL_EN is defined; otherwise MUL is flagged illegal.
module seq_alu
   import reg_seq_pkg::*;
(
   input  logic [2:0]    op,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   input  logic [4:0]    imm5,
   input  logic [8:0]    imm9,
   output logic [DW-1:0] result,
   output logic          illegal
);

   logic [DW-1:0] imm5_sx;

   assign imm5_sx = {{(DW-5){imm5[4]}}, imm5};

   // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      result  = '0;
      illegal = 1'b0;
      case (op)
         OP_LOAD: result = {{(DW-9){1'b0}}, imm9};
         OP_ADD:  result = a + b;
         OP_ADDI: result = a + imm5_sx;
         OP_SUB:  result = a - b;
         OP_SUBI: result = a - imm5_sx;
         OP_MUL: begin
`ifdef REG_SEQ_MUL_EN
            result = a * b;
`else
            illegal = 1'b1;
`endif
         end
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/reg_seq_ctrl.sv
// Instruction sequencer driving the 16x16 register file: IDLE/READ/WAIT/EXEC/WB
// FSM with registered outputs. MUL support is selected by REG_SEQ_MUL_EN.
module reg_seq_ctrl
   import reg_seq_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   reg_seq_ctrl_if.master bus
);

   seq_state_t    state_q, state_d;
   logic [DW-1:0] instr_q, instr_d;

   logic          mem_we_q, mem_we_d;
   logic [2:0]    mem_opcode_q, mem_opcode_d;
   logic [AW-1:0] mem_destino_q, mem_destino_d;
   logic [AW-1:0] mem_addr1_q, mem_addr1_d;
   logic [AW-1:0] mem_addr2_q, mem_addr2_d;
   logic [DW-1:0] mem_data_in_q, mem_data_in_d;
   logic [DW-1:0] disp_data_q, disp_data_d;
   logic          disp_valid_q, disp_valid_d;
   logic          err_q, err_d;

   // LOAD is resolved at acceptance, before the instruction register is loaded.
   logic [DW-1:0] dec_instr;
   logic [2:0]    dec_op;
   logic [DW-1:0] alu_result;
   logic          alu_illegal;

   assign dec_instr = (state_q == S_IDLE) ? bus.instr : instr_q;
   assign dec_op    = f_opcode(dec_instr);

   seq_alu u_alu (
      .op      (dec_op),
      .a       (bus.mem_rdata1),
      .b       (bus.mem_rdata2),
      .imm5    (f_imm5(dec_instr)),
      .imm9    (f_imm9(dec_instr)),
      .result  (alu_result),
      .illegal (alu_illegal)
   );

   always_comb begin
      state_d       = state_q;
      instr_d       = instr_q;
      mem_we_d      = 1'b0;
      mem_opcode_d  = OP_LOAD;
      mem_destino_d = mem_destino_q;
      mem_addr1_d   = mem_addr1_q;
      mem_addr2_d   = mem_addr2_q;
      mem_data_in_d = mem_data_in_q;
      disp_data_d   = disp_data_q;
      disp_valid_d  = 1'b0;
      err_d         = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.instr_valid) begin
               instr_d = bus.instr;
               case (dec_op)
                  OP_LOAD: begin
                     mem_we_d      = 1'b1;
                     mem_destino_d = f_rd(dec_instr);
                     mem_data_in_d = alu_result;
                     state_d       = S_WB;
                  end
                  OP_CLEAR: begin
                     mem_opcode_d = OP_CLEAR;
                     state_d      = S_WB;
                  end
                  default: begin
                     mem_addr1_d = f_rs1(dec_instr);
                     mem_addr2_d = f_rs2(dec_instr);
                     state_d     = S_READ;
                  end
               endcase
            end
         end
         S_READ: state_d = S_WAIT;
         S_WAIT: state_d = S_EXEC;
         S_EXEC: begin
            if (dec_op == OP_DISPLAY) begin
               disp_data_d  = bus.mem_rdata1;
               disp_valid_d = 1'b1;
               state_d      = S_IDLE;
            end else if (alu_illegal) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               mem_we_d      = 1'b1;
               mem_opcode_d  = dec_op;
               mem_destino_d = f_rd(dec_instr);
               mem_data_in_d = alu_result;
               state_d       = S_WB;
            end
         end
         S_WB:    state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         instr_q       <= '0;
         mem_we_q      <= 1'b0;
         mem_opcode_q  <= OP_LOAD;
         mem_destino_q <= '0;
         mem_addr1_q   <= '0;
         mem_addr2_q   <= '0;
         mem_data_in_q <= '0;
         disp_data_q   <= '0;
         disp_valid_q  <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         instr_q       <= instr_d;
         mem_we_q      <= mem_we_d;
         mem_opcode_q  <= mem_opcode_d;
         mem_destino_q <= mem_destino_d;
         mem_addr1_q   <= mem_addr1_d;
         mem_addr2_q   <= mem_addr2_d;
         mem_data_in_q <= mem_data_in_d;
         disp_data_q   <= disp_data_d;
         disp_valid_q  <= disp_valid_d;
         err_q         <= err_d;
      end
   end

   assign bus.instr_ready = (state_q == S_IDLE);
   assign bus.busy        = (state_q != S_IDLE);
   assign bus.mem_we      = mem_we_q;
   assign bus.mem_opcode  = mem_opcode_q;
   assign bus.mem_destino = mem_destino_q;
   assign bus.mem_addr1   = mem_addr1_q;
   assign bus.mem_addr2   = mem_addr2_q;
   assign bus.mem_data_in = mem_data_in_q;
   assign bus.disp_data   = disp_data_q;
   assign bus.disp_valid  = disp_valid_q;
   assign bus.err         = err_q;

endmodule

// File: tb/tb_reg_seq_ctrl.sv
// Self-checking bench for reg_seq_ctrl: directed cases plus random instructions
// against an instruction-level reference model and a behavioural register file.
module tb_reg_seq_ctrl;

   logic clk = 1'b0;
   logic rst;

   reg_seq_ctrl_if bus ();

   reg_seq_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

`ifdef REG_SEQ_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   // Register file: registered reads, write/clear at the clock edge, backdoor preload.
   logic [15:0] rf [16] = '{default: '0};
   logic        pre_we = 1'b0;
   logic [3:0]  pre_addr = '0;
   logic [15:0] pre_data = '0;

   always @(posedge clk) begin
      if (pre_we)
         rf[pre_addr] <= pre_data;
      else if (bus.mem_opcode == 3'b110)
         for (int i = 0; i < 16; i++) rf[i] <= '0;
      else if (bus.mem_we)
         rf[bus.mem_destino] <= bus.mem_data_in;
      bus.mem_rdata1 <= rf[bus.mem_addr1];
      bus.mem_rdata2 <= rf[bus.mem_addr2];
   end

   // Reference model state
   logic [15:0] ref_regs [16] = '{default: '0};
   logic [15:0] ref_disp = '0;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] mk(input int op, input int rd, input int low9);
      logic [15:0] w;
      w = {op[2:0], rd[3:0], low9[8:0]};
      return w;
   endfunction

   task automatic preload(input int addr, input logic [15:0] val);
      pre_we   = 1'b1;
      pre_addr = addr[3:0];
      pre_data = val;
      @(posedge clk);
      @(negedge clk);
      pre_we = 1'b0;
      ref_regs[addr] = val;
   endtask

   // Issue one instruction from a negedge with the sequencer idle, and check every
   // cycle until it is ready again.
   task automatic exec_instr(input logic [15:0] ins);
      int op, rd, rs1, rs2, imm5, imm9, sx, v, wb, done;
      longint p;
      bit writes, is_clear, is_disp, illegal, reads;
      logic [15:0] exp;
      op   = int'(ins[15:13]);
      rd   = int'(ins[12:9]);
      rs1  = int'(ins[8:5]);
      rs2  = int'(ins[4:1]);
      imm5 = int'(ins[4:0]);
      imm9 = int'(ins[8:0]);
      sx   = (imm5 >= 16) ? imm5 - 32 : imm5;
      exp  = '0;
      case (op)
         0: exp = imm9[15:0];
         1: begin v = int'(ref_regs[rs1]) + int'(ref_regs[rs2]); exp = v[15:0]; end
         2: begin v = int'(ref_regs[rs1]) + sx; exp = v[15:0]; end
         3: begin v = int'(ref_regs[rs1]) - int'(ref_regs[rs2]); exp = v[15:0]; end
         4: begin v = int'(ref_regs[rs1]) - sx; exp = v[15:0]; end
         5: begin p = longint'(ref_regs[rs1]) * longint'(ref_regs[rs2]); exp = p[15:0]; end
         7: exp = ref_regs[rs1];
         default: exp = '0;
      endcase
      is_clear = (op == 6);
      is_disp  = (op == 7);
      illegal  = (op == 5) && !MUL_EN;
      reads    = !(op == 0 || is_clear);
      writes   = !(is_clear || is_disp || illegal);
      wb       = reads ? 4 : 1;
      done     = !reads ? 2 : ((is_disp || illegal) ? 4 : 5);

      bus.instr       = ins;
      bus.instr_valid = 1'b1;
      check("ready_at_issue", bus.instr_ready, 1);
      @(posedge clk);
      @(negedge clk);
      bus.instr_valid = 1'b0;
      bus.instr       = 16'($urandom);
      for (int c = 1; c <= done; c++) begin
         if (c > 1) @(negedge clk);
         check("instr_ready", bus.instr_ready, (c == done));
         check("busy", bus.busy, (c != done));
         check("mem_we", bus.mem_we, (writes && c == wb));
         check("disp_valid", bus.disp_valid, (is_disp && c == 4));
         check("err", bus.err, (illegal && c == 4));
         check("disp_data", bus.disp_data, (is_disp && c >= 4) ? exp : ref_disp);
         if (c != wb)
            check("mem_opcode_idle", bus.mem_opcode, 3'b000);
         else if (is_clear)
            check("mem_opcode_clear", bus.mem_opcode, 3'b110);
         if (writes && c == wb) begin
            check("mem_destino", bus.mem_destino, rd[3:0]);
            check("mem_data_in", bus.mem_data_in, exp);
         end
         if (reads && c == 2) begin
            check("mem_addr1", bus.mem_addr1, rs1[3:0]);
            check("mem_addr2", bus.mem_addr2, rs2[3:0]);
         end
      end
      if (writes) ref_regs[rd] = exp;
      if (is_clear) for (int i = 0; i < 16; i++) ref_regs[i] = '0;
      if (is_disp) ref_disp = exp;
   endtask

   task automatic check_reset_values();
      check("rst_we", bus.mem_we, 0);
      check("rst_opcode", bus.mem_opcode, 3'b000);
      check("rst_destino", bus.mem_destino, 0);
      check("rst_addr1", bus.mem_addr1, 0);
      check("rst_addr2", bus.mem_addr2, 0);
      check("rst_data_in", bus.mem_data_in, 0);
      check("rst_disp_data", bus.disp_data, 0);
      check("rst_disp_valid", bus.disp_valid, 0);
      check("rst_err", bus.err, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_ready", bus.instr_ready, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int op;
      logic [15:0] ins;

      // Reset with a handshake offered: reset wins, nothing accepted.
      rst             = 1'b1;
      bus.instr       = mk(0, 3, 9'h1FF);
      bus.instr_valid = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_values();
      rst             = 1'b0;
      bus.instr_valid = 1'b0;
      @(negedge clk);
      check("post_rst_we", bus.mem_we, 0);

      exec_instr(mk(0, 3, 9'h1FF));

      preload(1, 16'h7FFF);
      preload(2, 16'h0001);
      exec_instr(mk(1, 4, {4'd1, 4'd2, 1'b0}));
      exec_instr(mk(3, 5, {4'd2, 4'd1, 1'b0}));
      exec_instr(mk(2, 6, {4'd1, 5'h1F}));
      exec_instr(mk(7, 0, {4'd6, 5'h00}));
      exec_instr(mk(6, 0, 9'h000));
      exec_instr(mk(7, 0, {4'd4, 5'h00}));

      preload(1, 16'h0100);
      exec_instr(mk(5, 7, {4'd1, 4'd1, 1'b0}));

      // Reset during WAIT of an ADD with instr_valid held high.
      preload(1, 16'h1234);
      preload(2, 16'h0101);
      bus.instr       = mk(1, 8, {4'd1, 4'd2, 1'b0});
      bus.instr_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      @(negedge clk);
      check("wait_busy", bus.busy, 1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_reset_values();
      bus.instr_valid = 1'b0;
      ref_disp        = '0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("abort_no_we", bus.mem_we, 0);
      end
      exec_instr(mk(1, 8, {4'd1, 4'd2, 1'b0}));
      exec_instr(mk(7, 0, {4'd8, 5'h00}));

      for (int n = 0; n < 60; n++) begin
         op = int'($urandom_range(0, 7));
         if (op == 6 && $urandom_range(0, 3) != 0) op = 0;
         ins = 16'($urandom);
         ins[15:13] = op[2:0];
         exec_instr(ins);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/reg_seq_ctrl.md
# reg_seq_ctrl

Instruction sequencer that owns the 16×16 register-file memory. Accepts one 16-bit instruction per valid/ready handshake, then decodes and sequences the register-file read, ALU execute and write-back cycles. Drives every register-file port (`we`, `opcode`, `destino`, `addr1`, `addr2`, `data_in`). Sits between the instruction source (switches/ROM front end) and the register file, and also produces the DISPLAY output.

## Interface
- `DW`, 16, data/instruction width
- `AW`, 4, register address width (16 registers)
- `clk` in 1: single clock, all logic rising-edge.
- `rst` in 1: reset, synchronous, active-high.
- `instr` in 16: instruction word.
  - [15:13] opcode
  - [12:9] rd
  - [8:5] rs1
  - [4:1] rs2
  - [4:0] imm5
  - [8:0] imm9
- `instr_valid` in 1: instruction offered.
- `instr_ready` out 1: high only in IDLE (combinational from state).
- `mem_we` out 1: register-file write enable.
- `mem_opcode` out 3: opcode forwarded to register file (110 = clear-all).
- `mem_destino` out 4: write address.
- `mem_addr1` out 4: read port 1 address.
- `mem_addr2` out 4: read port 2 address.
- `mem_data_in` out 16: write data.
- `mem_rdata1` in 16: register-file `data_out1` (registered, 1-cycle read latency).
- `mem_rdata2` in 16: register-file `data_out2` (registered, 1-cycle read latency).
- `disp_data` out 16: DISPLAY result, held until the next DISPLAY.
- `disp_valid` out 1: one-cycle pulse with new `disp_data`.
- `err` out 1: one-cycle pulse on an illegal opcode.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- Opcodes:
  - 000 LOAD: rd ← zero-extended imm9.
  - 001 ADD: rd ← rs1+rs2.
  - 010 ADDI: rd ← rs1 + sign-extended imm5.
  - 011 SUB: rd ← rs1−rs2.
  - 100 SUBI: rd ← rs1 − sign-extended imm5.
  - 101 MUL: rd ← low 16 bits of rs1×rs2.
  - 110 CLEAR: all registers ← 0.
  - 111 DISPLAY: disp_data ← rs1.
- Arithmetic is modulo 2^16, with no flags on carry or overflow.
- States: IDLE, READ, WAIT, EXEC, WB.
  - IDLE: on `instr_valid`, latch `instr`.
    - LOAD and CLEAR → WB.
    - All other opcodes → READ.
  - READ: drive `mem_addr1`/`mem_addr2` = rs1/rs2 → WAIT.
  - WAIT: the register file samples the addresses → EXEC.
  - EXEC: `mem_rdata1`/`mem_rdata2` are valid and the result is computed.
    - ALU ops: register `mem_data_in` = result, `mem_destino` = rd, `mem_we` = 1 → WB.
    - DISPLAY: `disp_data` = `mem_rdata1`, `disp_valid` = 1 → IDLE.
  - WB: `mem_we` or `mem_opcode` = 110 is held for exactly this cycle → IDLE.
- Outside WB, `mem_we` = 0 and `mem_opcode` = 000.
- CLEAR drives `mem_opcode` = 110 with `mem_we` = 0.
- Instructions are strictly serialised, so no hazards exist: a write completes before the next instruction's read.
- Illegal opcode (MUL when compiled out): `err` pulses one cycle, no write occurs, and the FSM returns to IDLE from EXEC.
- `instr` is ignored unless `instr_valid & instr_ready`.

## Timing
- Handshake accepted at edge T.
- Read-based ALU ops:
  - `mem_we` is high during cycle T+4.
  - The write lands at the end of that cycle.
  - `instr_ready` is high again in cycle T+5.
  - One instruction per 5 cycles.
- LOAD and CLEAR: WB during cycle T+1, ready again at T+2.
- DISPLAY: `disp_valid` is high during cycle T+4, ready in T+4 (EXEC → IDLE at the end of T+3).
- All `mem_*`, `disp_*` and `err` outputs are registered.
- Reset values:
  - State IDLE.
  - `mem_we` 0, `mem_opcode` 000.
  - `mem_destino`, `mem_addr1`, `mem_addr2`, `mem_data_in`, `disp_data` all 0.
  - `disp_valid` 0, `err` 0, `busy` 0.
  - `instr_ready` 1 after the reset cycle.
- Reset mid-operation: the instruction is abandoned. A write whose `mem_we` is already high in the reset cycle still completes in the register file; none is issued afterwards.
- `rst` has priority over a simultaneous handshake; the handshake is not accepted.

## Configuration
- `REG_SEQ_MUL_EN` defined: MUL (101) is implemented through the multiplier.
- `REG_SEQ_MUL_EN` undefined:
  - No multiplier is synthesised.
  - 101 is treated as illegal: `err` pulse, no write.
  - Timing is identical to the other read ops, minus the write.

## Structure
- Package `reg_seq_pkg` holds:
  - The opcode localparams `OP_LOAD` … `OP_DISPLAY`.
  - The state enum `seq_state_t`.
  - Instruction field position constants.
- Sub-module `seq_alu`: combinational op/a/b/imm → 16-bit result plus illegal flag; it contains the multiplier under the macro.

## Test plan
- Reset, then LOAD r3, imm9 = 0x1FF → `mem_we` = 1, `mem_destino` = 3, `mem_data_in` = 0x01FF in cycle T+1; `instr_ready` low in T+1.
- Preload r1 = 0x7FFF and r2 = 0x0001, then ADD r4, r1, r2 → `mem_data_in` = 0x8000 in T+4; SUB r5, r2, r1 → 0x8002.
- ADDI r6, r1, imm5 = 0x1F (−1) → 0x7FFE; DISPLAY r6 → `disp_valid` pulse, `disp_data` = 0x7FFE.
- CLEAR → `mem_opcode` = 110 for exactly one cycle with `mem_we` = 0; DISPLAY r4 afterwards → 0x0000.
- MUL r7, r1, r1 (r1 = 0x0100):
  - With `REG_SEQ_MUL_EN`: write 0x0000 (low 16 bits of 0x10000).
  - Without it: `err` pulse, `mem_we` stays 0.
- Assert `rst` during WAIT of an ADD while `instr_valid` is held high → no `mem_we` afterwards; `instr_ready` = 1 after the reset cycle; the next ADD completes normally.
